// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - sequential parametrised floating-point adder/subtractor with RNE rounding
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [EXP_W+MAN_W:0] i_in_a,
  input  logic [EXP_W+MAN_W:0] i_in_b,
  input  logic                 i_in_op,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [EXP_W+MAN_W:0] o_out_result,
  output logic [3:0]           o_out_flags
);

  localparam int W = 1 + EXP_W + MAN_W;
  // significand layout: [S-1] carry, [S-2] hidden, [S-3:2] fraction, [1] guard, [0] round
  localparam int S = MAN_W + 4;
  localparam logic [S-1:0]   ONE_S   = {{(S-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t         r_state;
  logic           r_sa, r_sb, r_sub, r_sign, r_sticky;
  logic [EXP_W:0] r_ea, r_eb, r_exp;
  logic [S-1:0]   r_ma, r_mb, r_man;
  logic           r_out_valid;
  logic [W-1:0]   r_out_result;
  logic [3:0]     r_out_flags;

  // operand decode at accept; B sign already reflects the requested operation
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_special;
  logic [W-1:0]     w_sp_result;
  logic             w_sp_invalid;

  assign w_sa      = i_in_a[W-1];
  assign w_sb      = i_in_b[W-1] ^ i_in_op;
  assign w_ea      = i_in_a[W-2:MAN_W];
  assign w_eb      = i_in_b[W-2:MAN_W];
  assign w_fa      = i_in_a[MAN_W-1:0];
  assign w_fb      = i_in_b[MAN_W-1:0];
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_max   = &w_ea;
  assign w_b_max   = &w_eb;
  assign w_a_nan   = w_a_max & (|w_fa);
  assign w_b_nan   = w_b_max & (|w_fb);
  assign w_a_inf   = w_a_max & ~(|w_fa);
  assign w_b_inf   = w_b_max & ~(|w_fb);
  assign w_special = w_a_zero | w_b_zero | w_a_max | w_b_max;

  // fast-path result for NaN / Inf / zero operands (subnormals count as zero)
  always_comb begin
    w_sp_result  = i_in_a;
    w_sp_invalid = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_sp_result  = QNAN;
      w_sp_invalid = 1'b1;
    end else if (w_a_inf) begin
      w_sp_result = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_sp_result = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_sp_result = {w_sa & w_sb, {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_sp_result = {w_sb, i_in_b[W-2:0]};
    end
  end

  // alignment: larger magnitude stays, smaller is shifted right with sticky collection
  logic           w_a_ge, w_big_s, w_far, w_lost;
  logic [EXP_W:0] w_big_e, w_sml_e, w_diff;
  logic [S-1:0]   w_big_m, w_sml_m, w_shifted;

  assign w_a_ge    = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_big_m   = w_a_ge ? r_ma : r_mb;
  assign w_sml_m   = w_a_ge ? r_mb : r_ma;
  assign w_big_e   = w_a_ge ? r_ea : r_eb;
  assign w_sml_e   = w_a_ge ? r_eb : r_ea;
  assign w_big_s   = w_a_ge ? r_sa : r_sb;
  assign w_diff    = w_big_e - w_sml_e;
  assign w_far     = 32'(w_diff) >= 32'(MAN_W + 3);
  assign w_shifted = w_sml_m >> w_diff;
  assign w_lost    = |(w_sml_m & ((ONE_S << w_diff) - ONE_S));

  // magnitude add/subtract; a set sticky means the true subtrahend is slightly larger, so borrow one LSB
  logic [S-1:0] w_sum;
  assign w_sum = r_sub ? (r_ma - r_mb - {{(S-1){1'b0}}, r_sticky}) : (r_ma + r_mb);

  logic [EXP_W:0] w_exp_dec;
  assign w_exp_dec = r_exp - EXP_ONE;

  // round to nearest even on guard/round/sticky; a fraction carry bumps the exponent
  logic           w_round_up, w_inexact;
  logic [MAN_W:0] w_frac_rnd;
  logic [EXP_W:0] w_exp_rnd;

  assign w_round_up = r_man[1] & (r_man[0] | r_sticky | r_man[2]);
  assign w_inexact  = r_man[1] | r_man[0] | r_sticky;
  assign w_frac_rnd = {1'b0, r_man[MAN_W+1:2]} + {{MAN_W{1'b0}}, w_round_up};
  assign w_exp_rnd  = r_exp + {{EXP_W{1'b0}}, w_frac_rnd[MAN_W]};

  assign o_in_ready   = (r_state == S_IDLE);
  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_out_flags  = r_out_flags;

  // operation sequencer and registered result/handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_sa         <= 1'b0;
      r_sb         <= 1'b0;
      r_sub        <= 1'b0;
      r_sign       <= 1'b0;
      r_sticky     <= 1'b0;
      r_ea         <= '0;
      r_eb         <= '0;
      r_exp        <= '0;
      r_ma         <= '0;
      r_mb         <= '0;
      r_man        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            if (w_special) begin
              r_out_result <= w_sp_result;
              r_out_flags  <= {w_sp_invalid, 3'b000};
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_sa    <= w_sa;
              r_sb    <= w_sb;
              r_sub   <= w_sa ^ w_sb;
              r_ea    <= {1'b0, w_ea};
              r_eb    <= {1'b0, w_eb};
              r_ma    <= {2'b01, w_fa, 2'b00};
              r_mb    <= {2'b01, w_fb, 2'b00};
              r_state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          r_ma     <= w_big_m;
          r_mb     <= w_far ? '0 : w_shifted;
          r_sticky <= w_far | w_lost;
          r_exp    <= w_big_e;
          r_sign   <= w_big_s;
          r_state  <= S_ADD;
        end
        S_ADD: begin
          if ((w_sum == '0) && !r_sticky) begin
            r_out_result <= '0;
            r_out_flags  <= 4'b0000;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_man   <= w_sum;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_man[S-1]) begin
            r_man    <= r_man >> 1;
            r_sticky <= r_sticky | r_man[0];
            r_exp    <= r_exp + EXP_ONE;
            r_state  <= S_ROUND;
          end else if (r_man[S-2]) begin
            r_state <= S_ROUND;
          end else if (w_exp_dec == '0) begin
            r_out_result <= {r_sign, {(W-1){1'b0}}};
            r_out_flags  <= 4'b0011;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_man <= r_man << 1;
            r_exp <= w_exp_dec;
          end
        end
        S_ROUND: begin
          if (w_exp_rnd >= EXP_INF) begin
            r_out_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_out_flags  <= 4'b0101;
          end else begin
            r_out_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
            r_out_flags  <= {3'b000, w_inexact};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
